// File: rtl/ik_swift_host.sv
// ik_swift_host: loads an IK job into a memory-mapped solver slave, starts it, polls for done, reads back DH params.
// Build option: define IK_SWIFT_HOST_TIMEOUT_EN to abort after POLL_TIMEOUT unsuccessful polls.
module ik_swift_host #(
  parameter int POLL_TIMEOUT = 65535,
  parameter int POLL_GAP     = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [107:0] job_target,
  input  logic [863:0] job_dh,
  output logic         result_valid,
  input  logic         result_ready,
  output logic [863:0] result_dh,
  output logic         result_timeout,
  output logic         busy,
  output logic         chipselect,
  output logic         write,
  output logic [5:0]   address,
  output logic [31:0]  writedata,
  input  logic [31:0]  readdata
);

  // state | meaning: IDLE wait job | LOAD 54 writes | START go | POLL_WAIT bus gap
  // POLL_RD done read | READBACK 48 reads | STOP clear go | RESULT hold results
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_POLL_WAIT, S_POLL_RD, S_READBACK, S_STOP, S_RESULT
  } state_t;

  // POLL_GAP must be at least 1; the gap timer counts down to 0 inclusive.
  localparam logic [15:0] GAP_LOAD = 16'(POLL_GAP - 1);

  state_t        state_q, state_d;
  logic [5:0]    idx_q, idx_d;
  logic          ph_q, ph_d;
  logic [15:0]   gap_q, gap_d;
  logic [971:0]  job_q, job_d;
  logic [863:0]  res_q, res_d;
  logic [4:0]    val_idx;
  logic [9:0]    val_base;
  logic [5:0]    hi_addr;
  logic [35:0]   load_val;
`ifdef IK_SWIFT_HOST_TIMEOUT_EN
  logic [31:0]   poll_q, poll_d;
  logic          timeout_q, timeout_d;
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    ph_d         = ph_q;
    gap_d        = gap_q;
    job_d        = job_q;
    res_d        = res_q;
`ifdef IK_SWIFT_HOST_TIMEOUT_EN
    poll_d       = poll_q;
    timeout_d    = timeout_q;
`endif
    job_ready    = 1'b0;
    result_valid = 1'b0;
    chipselect   = 1'b0;
    write        = 1'b0;
    address      = 6'd0;
    writedata    = 32'd0;

    // Each 36-bit value occupies a word pair; targets sit at 2..7, joints at 16..63.
    val_idx  = idx_q[5:1];
    val_base = 10'(val_idx) * 10'd36;
    load_val = job_q[val_base +: 36];
    hi_addr  = (val_idx < 5'd3) ? {val_idx, 1'b0} + 6'd2 : {val_idx, 1'b0} + 6'd10;

    case (state_q)
      S_IDLE: begin
        job_ready = 1'b1;
        if (job_valid) begin
          state_d = S_LOAD;
          job_d   = {job_dh, job_target};
          idx_d   = 6'd0;
          ph_d    = 1'b0;
          res_d   = '0;
`ifdef IK_SWIFT_HOST_TIMEOUT_EN
          poll_d    = 32'd0;
          timeout_d = 1'b0;
`endif
        end
      end
      S_LOAD: begin
        chipselect = 1'b1;
        write      = 1'b1;
        // Low word first: the slave clears the high bits on a low-word write.
        address    = {hi_addr[5:1], ~idx_q[0]};
        writedata  = idx_q[0] ? {28'd0, load_val[35:32]} : load_val[31:0];
        if (idx_q == 6'd53) begin
          idx_d   = 6'd0;
          state_d = S_START;
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end
      S_START: begin
        chipselect = 1'b1;
        write      = 1'b1;
        address    = 6'd1;
        writedata  = 32'd1;
        state_d    = S_POLL_WAIT;
        gap_d      = GAP_LOAD;
      end
      S_POLL_WAIT: begin
        if (gap_q == 16'd0) begin
          state_d = S_POLL_RD;
          ph_d    = 1'b0;
        end else begin
          gap_d = gap_q - 16'd1;
        end
      end
      S_POLL_RD: begin
        chipselect = 1'b1;
        address    = 6'd1;
        ph_d       = ~ph_q;
        if (ph_q) begin
          if (readdata[0]) begin
            state_d = S_READBACK;
            idx_d   = 6'd0;
          end else begin
`ifdef IK_SWIFT_HOST_TIMEOUT_EN
            if ((poll_q + 32'd1) >= 32'(POLL_TIMEOUT)) begin
              state_d   = S_STOP;
              timeout_d = 1'b1;
              res_d     = '0;
            end else begin
              poll_d  = poll_q + 32'd1;
              state_d = S_POLL_WAIT;
              gap_d   = GAP_LOAD;
            end
`else
            state_d = S_POLL_WAIT;
            gap_d   = GAP_LOAD;
`endif
          end
        end
      end
      S_READBACK: begin
        chipselect = 1'b1;
        address    = 6'd16 + idx_q;
        ph_d       = ~ph_q;
        if (ph_q) begin
          if (!idx_q[0]) res_d[val_base + 10'd32 +: 4] = readdata[3:0];
          else           res_d[val_base +: 32]         = readdata;
          if (idx_q == 6'd47) begin
            idx_d   = 6'd0;
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      S_STOP: begin
        chipselect = 1'b1;
        write      = 1'b1;
        address    = 6'd1;
        writedata  = 32'd0;
        state_d    = S_RESULT;
      end
      S_RESULT: begin
        result_valid = 1'b1;
        if (result_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= 6'd0;
      ph_q      <= 1'b0;
      gap_q     <= 16'd0;
      job_q     <= '0;
      res_q     <= '0;
`ifdef IK_SWIFT_HOST_TIMEOUT_EN
      poll_q    <= 32'd0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ph_q      <= ph_d;
      gap_q     <= gap_d;
      job_q     <= job_d;
      res_q     <= res_d;
`ifdef IK_SWIFT_HOST_TIMEOUT_EN
      poll_q    <= poll_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign result_dh = res_q;
`ifdef IK_SWIFT_HOST_TIMEOUT_EN
  assign result_timeout = timeout_q;
`else
  // Polling is unbounded here, so POLL_TIMEOUT can never fire.
  assign result_timeout = 1'b0 & (POLL_TIMEOUT == 0);
`endif

endmodule

// File: doc/ik_swift_host.md
IK_SWIFT_HOST -- requirements
Module: ik_swift_host

Interface
REQ-001 Parameter POLL_TIMEOUT, default 65535, maximum number of done-poll reads before abort (used only with IK_SWIFT_HOST_TIMEOUT_EN).
REQ-002 Parameter POLL_GAP, default 4, idle cycles between consecutive done-poll reads.
REQ-003 Port list, one per line:
- clk  input  1  sole clock, all logic on posedge
- reset  input  1  synchronous, active-high
- job_valid  input  1  job presented
- job_ready  output  1  block accepts a job
- job_target  input  3x36  target x,y,z, index 0 = x, signed Q16.16 sign-extended to 36 bits
- job_dh  input  6x4x36  DH params [joint][THETA,L_OFFSET,L_DISTANCE,ALPHA]
- result_valid  output  1  results held valid
- result_ready  input  1  consumer accepts results
- result_dh  output  6x4x36  read-back dh_param_out
- result_timeout  output  1  job aborted by poll timeout
- busy  output  1  any state other than IDLE
- chipselect  output  1  slave select
- write  output  1  write strobe
- address  output  6  slave word address
- writedata  output  32  write data
- readdata  input  32  slave read data, registered by the slave one cycle after the address is presented

Function
REQ-004 States: IDLE, LOAD, START, POLL_WAIT, POLL_RD, READBACK, STOP, RESULT.
REQ-005 IDLE: job_ready=1; on job_valid&job_ready, job_target and job_dh are latched internally and the FSM moves to LOAD.
REQ-006 LOAD: one write per cycle (chipselect=1, write=1); order is target 0..2 then joint 0..5, fields THETA,L_OFFSET,L_DISTANCE,ALPHA; 54 cycles total.
REQ-007 Each 36-bit value is written as the odd address first (writedata = bits 31:0), then the even address (writedata = {28'b0, bits 35:32}); the odd write clears bits 35:32 in the slave, so the reverse order is forbidden.
REQ-008 Address map: target n low/high = 3+2n / 2+2n; joint j field f low/high = 17+8j+2f / 16+8j+2f.
REQ-009 START: a single write of address 1, writedata 1; then POLL_WAIT.
REQ-010 POLL_WAIT: bus idle (chipselect=0) for POLL_GAP cycles; then POLL_RD.
REQ-011 Each read drives address with chipselect=1, write=0 for 2 cycles; readdata is captured at the end of the second cycle.
REQ-012 POLL_RD: reads address 1; if captured bit 0 = 1, go to READBACK, else return to POLL_WAIT.
REQ-013 READBACK: 48 reads of addresses 16..63 in ascending order (96 cycles); an even-address read supplies bits 35:32 from readdata[3:0], the next odd read supplies bits 31:0.
REQ-014 STOP: a single write of address 1, writedata 0; then RESULT.
REQ-015 RESULT: result_valid=1 and result_dh stable until result_ready is sampled high; the FSM then returns to IDLE in the same edge, and result_valid drops the next cycle.
REQ-016 job_valid outside IDLE is ignored; job inputs may change freely after acceptance.
REQ-017 When not in a bus state: chipselect=0, write=0, address=0, writedata=0.
REQ-018 result_timeout is 0 for a normal completion and is valid while result_valid=1.

Reset
REQ-019 With reset high at a clock edge, the FSM goes to IDLE and all outputs go to 0, except job_ready=1; result_dh and internal latches are cleared.
REQ-020 Reset mid-LOAD or mid-READBACK aborts the job without further bus traffic; the slave is assumed to be reset by the same reset.
REQ-021 The poll and gap counters reset to 0.

Configuration
REQ-022 Macro IK_SWIFT_HOST_TIMEOUT_EN, when defined, counts POLL_RD reads; when the count reaches POLL_TIMEOUT without done, the FSM goes to STOP, skips READBACK, result_dh = 0 and result_timeout = 1.
REQ-023 Without IK_SWIFT_HOST_TIMEOUT_EN, polling is unbounded and result_timeout is tied to 0.

Verification
REQ-024 Job target=(36'h1_0000_0000, 2, 3), all DH=5, slave model done after 10 polls -> 54 writes in the REQ-007/008 order, address 2 writedata 1, address 3 writedata 0, then the start write, 10 polls, 48 reads, the stop write, result_valid=1.
REQ-025 Slave returns dh_param_out[5][ALPHA]=36'hA_DEADBEEF -> result_dh[5][3]=36'hA_DEADBEEF.
REQ-026 result_ready held low for 20 cycles -> result_valid stays high, result_dh is unchanged, and job_ready=0 throughout.
REQ-027 Reset asserted at LOAD write 30 -> the next cycle has chipselect=0, busy=0, job_ready=1; a new job then completes normally.
REQ-028 With IK_SWIFT_HOST_TIMEOUT_EN and POLL_TIMEOUT=3, done never set -> 3 polls, then the stop write, result_timeout=1, result_dh=0, with no reads of addresses 16..63.
REQ-029 job_valid pulsed during POLL_WAIT -> the job is ignored and no second LOAD occurs.
